// File: rtl/rr_mux_pkg.sv
// Shared constants and FSM encoding for the 4:1 round-robin stream mux.
// The RR_MUX_PKT_EN build uses the LOCK state; beat-level builds use only ARB.
package rr_mux_pkg;
  localparam int CH_N       = 4;
  localparam int SEL_W      = 2;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;
endpackage

// File: rtl/rr_mux_4_1_arb.sv
// Combinational round-robin grant: first valid channel scanning from ptr,
// or only lock_ch while a packet lock is held.
module rr_arbiter_4
  import rr_mux_pkg::*;
(
  input  logic [CH_N-1:0]  in_valid,
  input  logic [SEL_W-1:0] ptr,
  input  logic             lock_en,
  input  logic [SEL_W-1:0] lock_ch,
  output logic [CH_N-1:0]  gnt_oh,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);
  logic [SEL_W-1:0] cand;

  always_comb begin
    gnt_idx = ptr;
    gnt_vld = 1'b0;
    cand    = ptr;
    if (lock_en) begin
      gnt_idx = lock_ch;
      gnt_vld = in_valid[lock_ch];
    end else begin
      // Walk from the farthest offset back to ptr so the nearest valid wins.
      for (int i = CH_N - 1; i >= 0; i--) begin
        cand = ptr + SEL_W'(i);
        if (in_valid[cand]) begin
          gnt_idx = cand;
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_oh          = '0;
    gnt_oh[gnt_idx] = gnt_vld;
  end
endmodule

// File: rtl/rr_mux_4_1.sv
// Four-channel round-robin stream mux with a registered, source-tagged output.
// Define RR_MUX_PKT_EN to add in_last/out_last and packet-level grant locking.
module rr_mux_4_1
  import rr_mux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CH_N-1:0]        in_valid,
  input  logic [CH_N*DATA_W-1:0] in_data,
  output logic [CH_N-1:0]        in_ready,
`ifdef RR_MUX_PKT_EN
  input  logic [CH_N-1:0]        in_last,
  output logic                   out_last,
`endif
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  input  logic                   out_ready
);
  logic [CH_N-1:0][DATA_W-1:0] din;
  logic [CH_N-1:0]             gnt_oh;
  logic [SEL_W-1:0]            gnt_idx;
  logic [SEL_W-1:0]            ptr;
  logic                        gnt_vld, load, acc, lock_en;

  assign din      = in_data;
  assign load     = !out_valid | out_ready;
  assign in_ready = load ? gnt_oh : '0;
  assign acc      = load & gnt_vld;

  // out_sel only changes on accepts, so while locked it names the owner.
  rr_arbiter_4 u_arb (
    .in_valid (in_valid),
    .ptr      (ptr),
    .lock_en  (lock_en),
    .lock_ch  (out_sel),
    .gnt_oh   (gnt_oh),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld)
  );

`ifdef RR_MUX_PKT_EN
  state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (acc) state_nxt = in_last[gnt_idx] ? ARB : LOCK;
  end

  always_comb begin
    lock_en = (state == LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out_last <= 1'b0;
    else if (acc) out_last <= in_last[gnt_idx];
  end
`else
  assign lock_en = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data  <= din[gnt_idx];
      out_sel   <= gnt_idx;
      ptr       <= gnt_idx + SEL_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_mux_4_1.sv
// Scoreboard bench for rr_mux_4_1: a driver predicts grants from a round-robin
// model and queues expected beats; a negedge monitor checks the output stream.
module tb_rr_mux_4_1;
  localparam int DW = 8;
`ifdef RR_MUX_PKT_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_ready;
  logic [3:0]    in_last;
  logic          out_valid, out_last, out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;

  always #5 clk = ~clk;

  rr_mux_4_1 #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef RR_MUX_PKT_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );
`ifndef RR_MUX_PKT_EN
  assign out_last = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    s;
    logic          l;
  } beat_t;
  beat_t q[$];

  int checks = 0;
  int errors = 0;
  int  mptr  = 0;
  bit  mov   = 1'b0;
  bit  mlock = 1'b0;
  int  mch   = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Fair arbitration rule: first valid channel at ptr, ptr+1, ... (mod 4),
  // restricted to the packet owner while a packet is open.
  function automatic int model_grant();
    for (int off = 0; off < 4; off++) begin
      int c;
      c = (mptr + off) % 4;
      if (mlock && c != mch) continue;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mptr = 0; mov = 1'b0; mlock = 1'b0; mch = 0;
    q.delete();
  endtask

  task automatic step();
    int g;
    bit ld;
    logic [3:0] er;
    beat_t b;
    @(negedge clk);
    ld = !mov || out_ready;
    g  = model_grant();
    er = 4'b0;
    if (ld && g >= 0) er[g] = 1'b1;
    chk("in_ready", in_ready, er);
    @(posedge clk);
    #1;
    if (ld && g >= 0) begin
      b.d = in_data[g*DW +: DW];
      b.s = 2'(g);
      b.l = PKT ? in_last[g] : 1'b0;
      q.push_back(b);
      mptr = (g + 1) % 4;
      mov  = 1'b1;
      if (PKT) begin
        mlock = !in_last[g];
        mch   = g;
      end
    end else if (out_ready) begin
      mov = 1'b0;
    end
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] v);
    in_data[k*DW +: DW] = v;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("out_data", {24'b0, out_data}, {24'b0, q[0].d});
        chk("out_sel",  {30'b0, out_sel},  {30'b0, q[0].s});
        chk("out_last", {31'b0, out_last}, {31'b0, q[0].l});
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    in_valid  = 4'b0;
    in_data   = '0;
    in_last   = 4'b1111;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_sel",   {30'b0, out_sel},   32'd0);
    chk("rst_out_data",  {24'b0, out_data},  32'd0);
    chk("rst_out_last",  {31'b0, out_last},  32'd0);
    chk("rst_in_ready",  {28'b0, in_ready},  32'd0);
    mon_en = 1'b1;

    out_ready = 1'b1;
    repeat (2) step();

    // All channels valid: expect 0,1,2,3,0 back to back.
    for (int k = 0; k < 4; k++) set_data(k, 8'hA0 + 8'(k));
    in_valid = 4'b1111;
    repeat (5) step();

    in_valid = 4'b1010;
    repeat (3) step();

    // Stall with 55 held, then release loads the queued ch0 beat on the same edge.
    in_valid = 4'b0100; set_data(2, 8'h55);
    step();
    in_valid = 4'b0001; set_data(0, 8'h77); out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    step();
    in_valid = 4'b0000;
    repeat (2) step();

    // Wrap 3 -> 0, then pointer must sit at 1.
    in_valid = 4'b1000; set_data(3, 8'h33);
    step();
    in_valid = 4'b0001; set_data(0, 8'h00);
    step();
    in_valid = 4'b1111;
    step();
    in_valid = 4'b0000;
    repeat (2) step();

    // Reset while a beat is stalled in the output register.
    in_valid = 4'b0001; set_data(0, 8'hC3);
    step();
    in_valid = 4'b0000; out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_out_data",  {24'b0, out_data},  32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    if (PKT) begin
      in_valid = 4'b0001; set_data(0, 8'h11); in_last = 4'b1111;
      step();
      in_valid = 4'b0111; in_last = 4'b1101;
      set_data(0, 8'h10); set_data(2, 8'h12); set_data(1, 8'hB1);
      step();
      set_data(1, 8'hB2);
      step();
      set_data(1, 8'hB3); in_last = 4'b1111;
      step();
      in_valid = 4'b0101;
      step();
      in_valid = 4'b0000;
      repeat (2) step();
    end

    for (int n = 0; n < 400; n++) begin
      in_valid  = 4'($urandom);
      in_data   = 32'($urandom);
      in_last   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    in_valid = 4'b0000; out_ready = 1'b1;
    repeat (3) step();
    chk("drain_empty", q.size(), 32'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_mux_4_1.md
# rr_mux_4_1

Four-channel round-robin stream multiplexer: collects valid/ready streams from four producers and serializes them onto one registered output stream, tagging each beat with its source channel. It is the gathering counterpart of the 1-to-4 demultiplexer: the demux fans a stream out by `sel`, and this block merges four streams back, generating `sel` itself by fair arbitration.

## Interface
- `DATA_W`, 8, width of each data beat
- `clk`  input  1  sole clock, rising-edge
- `rst_n`  input  1  asynchronous, active-low reset
- `in_valid`  input  4  per-channel beat valid, bit k = channel k
- `in_data`  input  4*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- `in_ready`  output  4  per-channel accept; at most one bit high
- `out_valid`  output  1  output beat valid
- `out_data`  output  DATA_W  output beat
- `out_sel`  output  2  source channel of the current output beat
- `out_ready`  input  1  downstream accept
- `in_last`  input  4  end-of-packet per channel (only with `RR_MUX_PKT_EN`)
- `out_last`  output  1  end-of-packet of the output beat (only with `RR_MUX_PKT_EN`)

## Operation
- A transfer occurs on any edge where valid and ready are both high on the same interface.
- `load` = !out_valid | out_ready. The output register accepts a new beat only when `load` is high.
- Arbiter: 2-bit pointer `ptr`. The grant is the first channel with `in_valid` high, scanning `ptr`, `ptr+1`, … mod 4.
- in_ready[k] = load & in_valid[k] & (grant == k). It is combinational and never high for more than one channel.
- On an accepted beat from channel k:
  - `out_data` <= that channel's data
  - `out_sel` <= k
  - `out_valid` <= 1
  - `ptr` <= (k+1) mod 4, wrapping 3 → 0
- If `out_ready` is high and no channel is valid, `out_valid` <= 0. `out_data` and `out_sel` hold their last values.
- While `out_valid & !out_ready`, all output registers hold and all `in_ready` bits are 0.
- No input may be accepted while the output register is stalled. No beat is dropped or duplicated.
- State machine (pointer only without the macro):
  - ARB: arbitrate on each `load` cycle.
  - LOCK: exists only with `RR_MUX_PKT_EN`; see Configuration.
- Reset: `out_valid`=0, `out_data`=0, `out_sel`=0, `out_last`=0, `ptr`=0, state=ARB. All registers reset asynchronously on the falling edge of `rst_n`.
- Reset asserted mid-packet or mid-stall discards the held beat, and `out_valid` drops immediately.

## Timing
- Latency: 1 cycle from input acceptance to `out_valid`.
- Throughput: 1 beat per cycle when `out_ready` is held high (bubble-free).
- Combinational paths: `in_valid` → `in_ready`, and `out_ready` → `in_ready`. There is no combinational path from any input to `out_*`.
- Simultaneous events: a downstream pop and an upstream accept on the same edge replace the output beat with no bubble.
- Fairness: with all four channels continuously valid, the grant order is 0,1,2,3,0,…. Each channel waits at most 3 transfers.

## Configuration
- `RR_MUX_PKT_EN` defined:
  - Adds the `in_last` and `out_last` ports and the LOCK state.
  - An accepted beat with in_last[k]=0 moves the FSM ARB → LOCK and freezes the grant on k.
  - In LOCK, only channel k can be granted. Other channels see `in_ready`=0 even when k is idle.
  - Accepting a beat from k with `in_last`=1 returns the FSM to ARB and sets `ptr` <= k+1.
  - A single-beat packet (`in_last`=1 on the first beat) stays in ARB.
  - `out_last` is registered alongside `out_data`.
- `RR_MUX_PKT_EN` undefined: beat-level arbitration only, with no `last` ports and no LOCK state.

## Structure
- Package `rr_mux_pkg`:
  - `CH_N`=4 and `SEL_W`=2
  - `DATA_W` default
  - FSM state enum (ARB, LOCK)
- Sub-module `rr_arbiter_4`: combinational round-robin grant from `in_valid`, `ptr` and an optional lock (`lock_en`, `lock_ch`). Outputs are a one-hot grant and an encoded index.
- Top level: output register, pointer/FSM update, `in_ready` generation.

## Test plan
- Reset, then in_valid=4'b0000 → out_valid=0, out_sel=0, in_ready=0. Asserting `rst_n`=0 while out_valid=1 → out_valid=0 before the next edge.
- All channels valid with data 8'hA0..8'hA3 and out_ready=1 → out_data sequence A0,A1,A2,A3,A0 on consecutive cycles, out_sel 0,1,2,3,0.
- in_valid=4'b1010 with ptr=0 → grant to ch1, then ch3, then ch1. Channels 0 and 2 never see `in_ready`.
- Beat 8'h55 on ch2, then out_ready=0 for 3 cycles → out_data holds 55, in_ready=0. out_ready=1 → the next beat is loaded on the same edge, with no bubble.
- Wrap: only ch3 valid, then only ch0 valid → out_sel 3 then 0, and the pointer returns to 1.
- With `RR_MUX_PKT_EN`: ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch2 are valid → three consecutive ch1 beats with out_last=0,0,1, then ch2 is granted.
